ul_ram_wr_ctrl: RTL and testbench

//   Write-side controller for the downhole uplink ping-pong frame RAM. Accepts a

---
 rtl/ul_ram_wr_ctrl.sv | 121 ++++++++++++
 tb/tb_ul_ram_wr_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ul_ram_wr_ctrl.sv
// Write-side controller for the uplink ping-pong frame RAM: fills two banks
// alternately from a framed word stream and hands full banks to the reader in order.
module ul_ram_wr_ctrl #(
  parameter int unsigned FRAME_LEN  = 262,
  parameter logic [9:0]  BANK0_BASE = 10'd0,
  parameter logic [9:0]  BANK1_BASE = 10'd512,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [9:0]       in_data,
  output logic             wrRAMEn,
  output logic [9:0]       wrRAMAddr,
  output logic [9:0]       wrRAMData,
  output logic [1:0]       UlRAM_wr_state,
  input  logic [1:0]       UlRAM_rd_state,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {B_FREE, B_FILL, B_FULL} bank_t;
  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;

  localparam logic [9:0] LAST_OFF = 10'(FRAME_LEN - 1);

  wstate_t          wstate_reg;
  bank_t            bank_reg [2];
  logic             wr_bank_reg;
  logic             rd_turn_reg;
  logic [9:0]       offset_reg;
  logic             wr_en_reg;
  logic [9:0]       wr_addr_reg;
  logic [9:0]       wr_data_reg;
  logic [1:0]       wr_state_reg;
  logic [CNT_W-1:0] drop_cnt_reg;
  logic [CNT_W-1:0] err_cnt_reg;

  logic       sof_word;
  logic       restart;
  logic       abort;
  logic       drop;
  logic       cont;
  logic       write;
  logic       last;
  logic [9:0] wr_off;
  logic [9:0] cur_base;
  logic [1:0] release_vec;

  // An sof during a fill frees the current bank and immediately reclaims it,
  // so an aborted frame always restarts in the same bank.
  always_comb begin
    sof_word    = in_valid & in_sof;
    abort       = sof_word && (wstate_reg == W_FILL);
    restart     = sof_word && ((wstate_reg == W_FILL) || (bank_reg[wr_bank_reg] == B_FREE));
    drop        = sof_word && (wstate_reg != W_FILL) && (bank_reg[wr_bank_reg] != B_FREE);
    cont        = in_valid && !in_sof && (wstate_reg == W_FILL);
    write       = restart | cont;
    wr_off      = restart ? 10'd0 : offset_reg;
    last        = write && (wr_off == LAST_OFF);
    cur_base    = wr_bank_reg ? BANK1_BASE : BANK0_BASE;
    release_vec = wr_state_reg & UlRAM_rd_state;
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      wstate_reg   <= W_IDLE;
      for (int b = 0; b < 2; b++) bank_reg[b] <= B_FREE;
      wr_bank_reg  <= 1'b0;
      rd_turn_reg  <= 1'b0;
      offset_reg   <= 10'd0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= 10'd0;
      wr_data_reg  <= 10'd0;
      wr_state_reg <= 2'b00;
      drop_cnt_reg <= '0;
      err_cnt_reg  <= '0;
    end else begin
      // Reader side: only the bank whose turn it is may be offered.
      for (int b = 0; b < 2; b++) begin
        if (release_vec[b]) begin
          wr_state_reg[b] <= 1'b0;
          bank_reg[b]     <= B_FREE;
        end else if (bank_reg[b] == B_FULL && rd_turn_reg == 1'(b)) begin
          wr_state_reg[b] <= 1'b1;
        end
      end
      if (release_vec != 2'b00) rd_turn_reg <= ~rd_turn_reg;

      // Writer side never touches a FULL bank, so it cannot collide with a release.
      wr_en_reg <= write;
      if (write) begin
        wr_addr_reg <= cur_base + wr_off;
        wr_data_reg <= in_data;
        if (last) begin
          bank_reg[wr_bank_reg] <= B_FULL;
          wr_bank_reg           <= ~wr_bank_reg;
          wstate_reg            <= W_IDLE;
        end else begin
          bank_reg[wr_bank_reg] <= B_FILL;
          offset_reg            <= wr_off + 10'd1;
          wstate_reg            <= W_FILL;
        end
      end else if (drop) begin
        wstate_reg <= W_DROP;
      end

      if (abort && err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + 1'b1;
      if (drop && drop_cnt_reg != '1) drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

  assign wrRAMEn        = wr_en_reg;
  assign wrRAMAddr      = wr_addr_reg;
  assign wrRAMData      = wr_data_reg;
  assign UlRAM_wr_state = wr_state_reg;
  assign drop_cnt       = drop_cnt_reg;
  assign err_cnt        = err_cnt_reg;

endmodule

// File: tb/tb_ul_ram_wr_ctrl.sv
// Scoreboard bench for ul_ram_wr_ctrl: a frame-level model predicts writes and
// publications; a monitor compares them as the DUT produces them.
module tb_ul_ram_wr_ctrl;

  localparam int FL = 262;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [9:0] in_data = 10'd0;
  logic [1:0] rd_state = 2'b00;
  logic       wrRAMEn;
  logic [9:0] wrRAMAddr;
  logic [9:0] wrRAMData;
  logic [1:0] wr_state;
  logic [7:0] drop_cnt;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  ul_ram_wr_ctrl dut (
    .clk            (clk),
    .nRst           (nRst),
    .in_valid       (in_valid),
    .in_sof         (in_sof),
    .in_data        (in_data),
    .wrRAMEn        (wrRAMEn),
    .wrRAMAddr      (wrRAMAddr),
    .wrRAMData      (wrRAMData),
    .UlRAM_wr_state (wr_state),
    .UlRAM_rd_state (rd_state),
    .drop_cnt       (drop_cnt),
    .err_cnt        (err_cnt)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Frame-level reference model
  bit         m_filling;
  bit         m_wr_bank;
  bit         m_free [2];
  int         exp_drop;
  int         exp_err;
  logic [9:0] cur_frame [$];
  logic [19:0] wq [$];
  bit         pq_bank [$];
  logic [9:0] pq_data [$];
  logic [9:0] tb_ram [1024];

  function automatic logic [9:0] base_of(input bit b);
    return b ? 10'd512 : 10'd0;
  endfunction

  task automatic model_word(input bit v, input bit s, input logic [9:0] d);
    if (!v) return;
    if (m_filling && s) begin
      if (exp_err < 255) exp_err++;
      m_filling = 0;
      m_free[m_wr_bank] = 1;
    end
    if (m_filling) begin
      wq.push_back({10'(base_of(m_wr_bank) + 10'(cur_frame.size())), d});
      cur_frame.push_back(d);
      if (cur_frame.size() == FL) begin
        pq_bank.push_back(m_wr_bank);
        foreach (cur_frame[i]) pq_data.push_back(cur_frame[i]);
        m_wr_bank = !m_wr_bank;
        m_filling = 0;
      end
    end else if (s) begin
      if (m_free[m_wr_bank]) begin
        m_free[m_wr_bank] = 0;
        m_filling = 1;
        cur_frame.delete();
        cur_frame.push_back(d);
        wq.push_back({base_of(m_wr_bank), d});
      end else if (exp_drop < 255) begin
        exp_drop++;
      end
    end
  endtask

  // Reader emulation
  bit ack_en = 0;
  int age = 0;
  int ack_dly = 2;
  bit chk_rel = 0;
  bit rel_bank = 0;

  task automatic step(input bit v, input bit s, input logic [9:0] d);
    logic [1:0] ws;
    bit ack;
    bit ab;
    @(negedge clk);
    ws = wr_state;
    ack = 0;
    ab = 0;
    if (chk_rel) begin
      chk("release_clear", {31'd0, ws[rel_bank]}, 32'd0);
      chk_rel = 0;
    end
    if (ack_en && ws != 2'b00) begin
      age++;
      if (age >= ack_dly) begin
        ack = 1;
        ab = ws[1];
        age = 0;
        ack_dly = $urandom_range(1, 6);
      end
    end else begin
      age = 0;
    end
    rd_state = (ack ? ws : 2'b00) | (2'($urandom) & ~ws);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    model_word(v, s, d);
    if (ack) begin
      m_free[ab] = 1;
      chk_rel = 1;
      rel_bank = ab;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 10'($urandom));
  endtask

  task automatic send_frame(input int n, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < gap_pct) idle(1);
      step(1'b1, i == 0, 10'($urandom));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nRst = 0;
    in_valid = 0;
    in_sof = 0;
    rd_state = 2'b00;
    repeat (2) @(negedge clk);
    chk("reset_wr_port", {11'd0, wrRAMEn, wrRAMAddr, wrRAMData}, 32'd0);
    chk("reset_state", {14'd0, wr_state, drop_cnt, err_cnt}, 32'd0);
    m_filling = 0;
    m_wr_bank = 0;
    m_free[0] = 1;
    m_free[1] = 1;
    exp_drop = 0;
    exp_err = 0;
    cur_frame.delete();
    wq.delete();
    pq_bank.delete();
    pq_data.delete();
    age = 0;
    chk_rel = 0;
    nRst = 1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pq_bank.size() != 0 || wq.size() != 0 || wr_state != 2'b00) && n < 3000) begin
      idle(1);
      n++;
    end
    idle(3);
    chk("drain_done", {31'd0, pq_bank.size() == 0 && wq.size() == 0}, 32'd1);
  endtask

  task automatic check_counters();
    idle(2);
    chk("drop_cnt", {24'd0, drop_cnt}, 32'(exp_drop));
    chk("err_cnt", {24'd0, err_cnt}, 32'(exp_err));
  endtask

  // Monitor: pops expected writes and publications as the DUT presents them
  initial begin
    logic [1:0] prev_ws;
    logic [1:0] rise;
    logic [19:0] e;
    logic [9:0] d;
    bit b;
    int mism;
    prev_ws = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (wrRAMEn) begin
        if (wq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_write: got addr %0d data %0h, required no write", wrRAMAddr, wrRAMData);
        end else begin
          e = wq.pop_front();
          chk("write", {12'd0, wrRAMAddr, wrRAMData}, {12'd0, e});
        end
        tb_ram[wrRAMAddr] = wrRAMData;
      end
      if (wr_state == 2'b11) chk("wr_state_onehot", {30'd0, wr_state}, 32'd0);
      rise = wr_state & ~prev_ws;
      if (rise != 2'b00) begin
        if (pq_bank.size() == 0) begin
          checks++;
          $display("FAIL unexpected_publish: got wr_state %b, required none", wr_state);
        end else begin
          b = pq_bank.pop_front();
          chk("publish_bank", {30'd0, rise}, b ? 32'd2 : 32'd1);
          mism = 0;
          for (int i = 0; i < FL; i++) begin
            d = pq_data.pop_front();
            if (tb_ram[base_of(b) + 10'(i)] !== d) mism++;
          end
          chk("frame_contents", 32'(mism), 32'd0);
        end
      end
      prev_ws = wr_state;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, required finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Single frame, held until acknowledged
    ack_en = 0;
    send_frame(FL, 0);
    idle(5);
    chk("single_wr_state", {30'd0, wr_state}, 32'd1);
    ack_en = 1;
    drain();
    check_counters();

    // Both banks full, third frame dropped, fourth frame after release
    do_reset();
    ack_en = 0;
    send_frame(FL, 0);
    send_frame(FL, 0);
    idle(5);
    chk("two_full_wr_state", {30'd0, wr_state}, 32'd1);
    send_frame(FL, 0);
    idle(3);
    chk("drop_cnt_one", {24'd0, drop_cnt}, 32'd1);
    ack_en = 1;
    idle(20);
    send_frame(FL, 0);
    drain();
    check_counters();

    // Early sof aborts a bank-0 fill
    do_reset();
    send_frame(100, 0);
    send_frame(FL, 0);
    drain();
    check_counters();

    // Reset in the middle of a fill
    do_reset();
    send_frame(50, 0);
    do_reset();
    send_frame(FL, 0);
    drain();
    check_counters();

    // Stalled stream over three frames
    do_reset();
    for (int f = 0; f < 3; f++) send_frame(FL, 30);
    drain();
    check_counters();

    // Random mix of gaps, partial frames and reader delays
    for (int f = 0; f < 8; f++) begin
      idle($urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) send_frame($urandom_range(1, FL - 1), $urandom_range(0, 40));
      else send_frame(FL, $urandom_range(0, 40));
    end
    send_frame(FL, 10);
    drain();
    check_counters();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
